// File: rtl/config_bus_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ write-only Avalon-MM sequencers onto one shared bus.
// Optional XFER watchdog with sticky per-requester error flags: define CONFIG_ARB_TIMEOUT_EN.
module config_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writedata,
    output logic [NUM_REQ-1:0]            req_waitrequest,
    input  logic [NUM_REQ-1:0]            req_completed,
    input  logic                          amm_waitrequest,
    output logic                          amm_write,
    output logic [ADDR_WIDTH-1:0]         amm_address,
    output logic [DATA_WIDTH-1:0]         amm_writedata,
    output logic [$clog2(NUM_REQ)-1:0]    grant,
    output logic                          all_completed,
    output logic [NUM_REQ-1:0]            timeout_err,
    output logic [1:0]                    dbg_state
);

    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("config_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [GW-1:0]         r_grant, w_grant_nxt;
    logic [GW-1:0]         r_last_grant, w_last_grant_nxt;
    logic [GW-1:0]         w_winner;
    logic                  w_found;
    logic                  r_amm_write, w_amm_write_nxt;
    logic [ADDR_WIDTH-1:0] r_amm_address, w_amm_address_nxt;
    logic [DATA_WIDTH-1:0] r_amm_writedata, w_amm_writedata_nxt;
    logic                  r_all_completed;
    logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

`ifdef CONFIG_ARB_TIMEOUT_EN
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0]      r_xfer_cnt, w_xfer_cnt_nxt;
    logic [NUM_REQ-1:0] r_timeout_err, w_timeout_err_nxt;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data_arr[g] = req_writedata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[GW-1:0];
    endfunction

    // Search starts one past the last winner so a held request is served within NUM_REQ transfers.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!w_found && req_write[rr_index(r_last_grant, off)]) begin
                w_found  = 1'b1;
                w_winner = rr_index(r_last_grant, off);
            end
        end
    end

    // Handshake: amm_write is valid, ~amm_waitrequest is ready; a beat transfers on a clock where both
    // hold. Towards requesters, req_waitrequest low for one cycle means that requester's write was taken.
    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        w_last_grant_nxt    = r_last_grant;
        w_amm_write_nxt     = r_amm_write;
        w_amm_address_nxt   = r_amm_address;
        w_amm_writedata_nxt = r_amm_writedata;
`ifdef CONFIG_ARB_TIMEOUT_EN
        w_xfer_cnt_nxt      = r_xfer_cnt;
        w_timeout_err_nxt   = r_timeout_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt         = S_XFER;
                    w_grant_nxt         = w_winner;
                    w_last_grant_nxt    = w_winner;
                    w_amm_write_nxt     = 1'b1;
                    w_amm_address_nxt   = w_addr_arr[w_winner];
                    w_amm_writedata_nxt = w_data_arr[w_winner];
`ifdef CONFIG_ARB_TIMEOUT_EN
                    w_xfer_cnt_nxt      = '0;
`endif
                end
            end
            S_XFER: begin
                if (!amm_waitrequest) begin
                    w_amm_write_nxt = 1'b0;
                    w_state_nxt     = S_ACK;
                end
`ifdef CONFIG_ARB_TIMEOUT_EN
                else if (r_xfer_cnt == TO_LAST) begin
                    // Release the stuck requester so its sequence can carry on.
                    w_amm_write_nxt            = 1'b0;
                    w_timeout_err_nxt[r_grant] = 1'b1;
                    w_state_nxt                = S_ACK;
                end else begin
                    w_xfer_cnt_nxt = r_xfer_cnt + CW'(1);
                end
`endif
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_last_grant    <= GW'(NUM_REQ - 1);
            r_amm_write     <= 1'b0;
            r_amm_address   <= '0;
            r_amm_writedata <= '0;
            r_all_completed <= 1'b0;
`ifdef CONFIG_ARB_TIMEOUT_EN
            r_xfer_cnt      <= '0;
            r_timeout_err   <= '0;
`endif
        end else begin
            r_state         <= w_state_nxt;
            r_grant         <= w_grant_nxt;
            r_last_grant    <= w_last_grant_nxt;
            r_amm_write     <= w_amm_write_nxt;
            r_amm_address   <= w_amm_address_nxt;
            r_amm_writedata <= w_amm_writedata_nxt;
            r_all_completed <= (&req_completed) && (r_state == S_IDLE) && (req_write == '0);
`ifdef CONFIG_ARB_TIMEOUT_EN
            r_xfer_cnt      <= w_xfer_cnt_nxt;
            r_timeout_err   <= w_timeout_err_nxt;
`endif
        end
    end

    always_comb begin
        req_waitrequest = '1;
        if (r_state == S_ACK) req_waitrequest[r_grant] = 1'b0;
    end

    assign amm_write     = r_amm_write;
    assign amm_address   = r_amm_address;
    assign amm_writedata = r_amm_writedata;
    assign grant         = r_grant;
    assign all_completed = r_all_completed;
    assign dbg_state     = r_state;
`ifdef CONFIG_ARB_TIMEOUT_EN
    assign timeout_err   = r_timeout_err;
`else
    assign timeout_err   = '0;
`endif

endmodule

// File: doc/config_bus_arbiter.md
# config_bus_arbiter

Round-robin arbiter that shares one Avalon-MM write-only master port between `NUM_REQ` configuration sequencers. Each sequencer is a ROM-driven register writer. The arbiter sits between these sequencers and a single shared register bus, such as a bridge to a video-chip or PLL control interface. It serialises their writes one transfer at a time and reports when every requester has finished.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 32: address width on every port.
- `DATA_WIDTH`, default 8: write data width on every port.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in clocks. Used only with `CONFIG_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_write`  in  NUM_REQ  per-requester write strobe.
- `req_address`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_writedata`  in  NUM_REQ*DATA_WIDTH  packed write data, sliced the same way.
- `req_waitrequest`  out  NUM_REQ  per-requester waitrequest; low for exactly one cycle = write accepted.
- `req_completed`  in  NUM_REQ  per-requester "sequence finished" level.
- `amm_waitrequest`  in  1  shared bus waitrequest.
- `amm_write`  out  1  shared bus write strobe.
- `amm_address`  out  ADDR_WIDTH  shared bus address.
- `amm_writedata`  out  DATA_WIDTH  shared bus write data.
- `grant`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `all_completed`  out  1  every requester has finished and the bus is idle.
- `timeout_err`  out  NUM_REQ  sticky per-requester timeout flags.

## Operation
- State machine: IDLE -> XFER -> ACK -> IDLE.
- IDLE:
  - If any `req_write` bit is set, select the winner by round-robin. The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - Latch the winner's address and data into `amm_address`/`amm_writedata`.
  - Set `amm_write`=1, `grant`=winner, `last_grant`=winner; go to XFER.
- XFER:
  - Hold `amm_write`/`amm_address`/`amm_writedata` stable.
  - When `amm_waitrequest`=0, clear `amm_write` and go to ACK.
  - Requester inputs are ignored in this state; changes to them do not affect the transfer in flight.
- ACK:
  - Drive `req_waitrequest[grant]`=0 for this single cycle; go to IDLE.
  - The requester deasserts or advances its write on this edge.
  - IDLE does not arbitrate on the ACK cycle's inputs. The first IDLE cycle samples the requester's updated strobe.
- `req_waitrequest` for non-granted requesters is always 1.
- Round-robin guarantees service within `NUM_REQ` transfers for any continuously asserted requester.
- `all_completed` (registered) = AND of all `req_completed` AND state==IDLE AND `req_write`==0.
- Reset values:
  - `amm_write`=0, `amm_address`=0, `amm_writedata`=0.
  - `req_waitrequest`=all 1.
  - `grant`=0, `last_grant`=NUM_REQ-1, so requester 0 has first priority.
  - `all_completed`=0, `timeout_err`=0.
  - State = IDLE.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronously). No ACK is issued for the aborted write.

## Timing
- Request seen in IDLE at cycle 0 -> `amm_write`=1 from cycle 1.
- Bus accepts at cycle k (k>=1, `amm_waitrequest` low) -> `req_waitrequest[g]`=0 at cycle k+1 -> IDLE at k+2.
- Minimum 3 clocks per transfer with zero-wait bus; back-to-back transfers every 3 clocks.
- Simultaneous requests resolve in the same IDLE cycle; no extra latency for contention.
- `all_completed` lags its inputs by one clock.

## Configuration
- Macro: `CONFIG_ARB_TIMEOUT_EN`.
- Defined:
  - An XFER cycle counter (width $clog2(TIMEOUT_CYCLES+1)) is cleared on entry to XFER.
  - If it reaches `TIMEOUT_CYCLES` with `amm_waitrequest` still 1: drop `amm_write`, set `timeout_err[grant]` (sticky until reset), and go to ACK. The requester is released so it can continue its sequence.
- Undefined:
  - No counter; XFER waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Single requester: `req_write[2]`=1, addr 0x0000_0010, data 0xA5, bus zero-wait -> `amm_write` cycle 1 with 0x10/0xA5, `req_waitrequest[2]`=0 at cycle 2 only, `grant`=2.
- Contention after reset: `req_write`=4'b1001 simultaneously -> requester 0 served first, then 3; never two writes overlapping.
- Fairness: requesters 0, 1, 3 held continuously for 9 transfers -> grant order 0,1,3,0,1,3,0,1,3.
- Stretched bus: `amm_waitrequest` high 5 cycles -> `amm_write`/`amm_address`/`amm_writedata` stable for 6 cycles; requester ACK one cycle after acceptance.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): bus stuck high -> `amm_write` drops after 16 XFER cycles, `timeout_err[1]`=1, requester 1 ACKed, next requester then served.
- Completion plus mid-transfer reset: all `req_completed`=1 and bus idle -> `all_completed`=1 one clock later. Assert `reset_n`=0 during XFER -> `amm_write`=0 immediately, `all_completed`=0, and after release requester 0 has priority.
